// File: rtl/axi_rd_subordinate.sv
// AXI4 read-only subordinate that stands in for DDR behind the prefetcher.
// It accepts AR requests into an in-order queue and waits a fixed latency
// after the previous burst completes. It then returns an INCR burst whose
// beat data is the beat's byte address, or zero for out-of-window requests.
module axi_rd_subordinate #(
    parameter int ADDR_BITS       = 64,
    parameter int DATA_WIDTH      = 64,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int TID_WIDTH       = 8,
    parameter int LOG_OUTSTANDING = 2,
    parameter int READ_LATENCY    = 4
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic [ADDR_BITS-1:0]       bar,
    input  logic [ADDR_BITS-1:0]       limit,
    input  logic                       s_ar_valid,
    output logic                       s_ar_ready,
    input  logic [ADDR_BITS-1:0]       s_ar_addr,
    input  logic [BURST_LEN_WIDTH-1:0] s_ar_len,
    input  logic [TID_WIDTH-1:0]       s_ar_id,
    output logic                       s_r_valid,
    input  logic                       s_r_ready,
    output logic [TID_WIDTH-1:0]       s_r_id,
    output logic [DATA_WIDTH-1:0]      s_r_data,
    output logic [1:0]                 s_r_resp,
    output logic                       s_r_last,
    output logic [LOG_OUTSTANDING:0]   outstanding
);

    localparam int DEPTH  = 1 << LOG_OUTSTANDING;
    localparam int PTR_W  = LOG_OUTSTANDING;
    localparam int CNT_W  = LOG_OUTSTANDING + 1;
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int WAIT_W = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
    localparam int MAXW   = (DATA_WIDTH > ADDR_BITS) ? DATA_WIDTH : ADDR_BITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    // Beat payload: the byte address resized to the data bus, or zero on error.
    function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [ADDR_BITS-1:0] addr,
                                                        input logic err);
        logic [MAXW-1:0] wide;
        wide = '0;
        wide[ADDR_BITS-1:0] = addr;
        if (err) begin
            beat_data = '0;
        end else begin
            beat_data = wide[DATA_WIDTH-1:0];
        end
    endfunction

    // Response code carried by every beat of a burst.
    function automatic logic [1:0] resp_code(input logic err);
        if (err) begin
            resp_code = 2'b10;
        end else begin
            resp_code = 2'b00;
        end
    endfunction

    // Request queue
    logic [ADDR_BITS-1:0]       q_addr_r [DEPTH];
    logic [BURST_LEN_WIDTH-1:0] q_len_r  [DEPTH];
    logic [TID_WIDTH-1:0]       q_id_r   [DEPTH];
    logic                       q_err_r  [DEPTH];
    logic [PTR_W-1:0]           wr_ptr_r;
    logic [PTR_W-1:0]           rd_ptr_r;
    logic [CNT_W-1:0]           count_r;
    logic [CNT_W-1:0]           count_nxt_s;
    logic                       ar_ready_r;
    logic                       ar_ready_nxt_s;

    // Sequencer and R channel registers
    state_t                     state_r;
    state_t                     state_nxt_s;
    logic [WAIT_W-1:0]          wait_r;
    logic [WAIT_W-1:0]          wait_nxt_s;
    logic [BURST_LEN_WIDTH-1:0] beat_r;
    logic [BURST_LEN_WIDTH-1:0] beat_nxt_s;
    logic [BURST_LEN_WIDTH-1:0] beat_inc_s;
    logic [ADDR_BITS-1:0]       beat_addr_r;
    logic [ADDR_BITS-1:0]       beat_addr_nxt_s;
    logic [ADDR_BITS-1:0]       beat_addr_inc_s;
    logic                       r_valid_r;
    logic                       r_valid_nxt_s;
    logic [TID_WIDTH-1:0]       r_id_r;
    logic [TID_WIDTH-1:0]       r_id_nxt_s;
    logic [DATA_WIDTH-1:0]      r_data_r;
    logic [DATA_WIDTH-1:0]      r_data_nxt_s;
    logic [1:0]                 r_resp_r;
    logic [1:0]                 r_resp_nxt_s;
    logic                       r_last_r;
    logic                       r_last_nxt_s;

    logic                       ar_hs_s;
    logic                       ar_err_s;
    logic                       r_hs_s;
    logic                       launch_s;
    logic                       advance_s;
    logic                       pop_s;
    logic [ADDR_BITS-1:0]       head_addr_s;
    logic [BURST_LEN_WIDTH-1:0] head_len_s;
    logic [TID_WIDTH-1:0]       head_id_s;
    logic                       head_err_s;

    assign ar_hs_s         = s_ar_valid & ar_ready_r;
    assign ar_err_s        = (s_ar_addr < bar) || (s_ar_addr > limit);
    assign r_hs_s          = r_valid_r & s_r_ready;
    assign head_addr_s     = q_addr_r[rd_ptr_r];
    assign head_len_s      = q_len_r[rd_ptr_r];
    assign head_id_s       = q_id_r[rd_ptr_r];
    assign head_err_s      = q_err_r[rd_ptr_r];
    assign beat_inc_s      = beat_r + BURST_LEN_WIDTH'(1'b1);
    assign beat_addr_inc_s = beat_addr_r + ADDR_BITS'(BYTES);

    assign s_ar_ready  = ar_ready_r;
    assign s_r_valid   = r_valid_r;
    assign s_r_id      = r_id_r;
    assign s_r_data    = r_data_r;
    assign s_r_resp    = r_resp_r;
    assign s_r_last    = r_last_r;
    assign outstanding = count_r;

    // Occupancy after this edge; the head stays counted until its last beat.
    always_comb begin
        count_nxt_s    = count_r + CNT_W'(ar_hs_s) - CNT_W'(pop_s);
        ar_ready_nxt_s = (count_nxt_s < CNT_W'(DEPTH));
    end

    // Sequencer next state: latency countdown, burst launch, beat advance, pop.
    always_comb begin
        state_nxt_s = state_r;
        wait_nxt_s  = wait_r;
        launch_s    = 1'b0;
        advance_s   = 1'b0;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (count_r != '0) begin
                    if (READ_LATENCY == 1) begin
                        launch_s    = 1'b1;
                        state_nxt_s = ST_BURST;
                    end else begin
                        wait_nxt_s  = WAIT_W'(READ_LATENCY - 2);
                        state_nxt_s = ST_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_r == '0) begin
                    launch_s    = 1'b1;
                    state_nxt_s = ST_BURST;
                end else begin
                    wait_nxt_s  = wait_r - WAIT_W'(1'b1);
                end
            end
            ST_BURST: begin
                if (r_hs_s) begin
                    if (r_last_r) begin
                        pop_s       = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        advance_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_BURST;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // R channel next values; everything holds unless a beat is launched or retired.
    always_comb begin
        beat_nxt_s      = beat_r;
        beat_addr_nxt_s = beat_addr_r;
        r_valid_nxt_s   = r_valid_r;
        r_id_nxt_s      = r_id_r;
        r_data_nxt_s    = r_data_r;
        r_resp_nxt_s    = r_resp_r;
        r_last_nxt_s    = r_last_r;
        if (launch_s) begin
            beat_nxt_s      = '0;
            beat_addr_nxt_s = head_addr_s;
            r_valid_nxt_s   = 1'b1;
            r_id_nxt_s      = head_id_s;
            r_data_nxt_s    = beat_data(head_addr_s, head_err_s);
            r_resp_nxt_s    = resp_code(head_err_s);
            r_last_nxt_s    = (head_len_s == '0);
        end else if (advance_s) begin
            // Only taken below the last beat, so the beat index cannot wrap.
            beat_nxt_s      = beat_inc_s;
            beat_addr_nxt_s = beat_addr_inc_s;
            r_data_nxt_s    = beat_data(beat_addr_inc_s, head_err_s);
            r_last_nxt_s    = (beat_inc_s == head_len_s);
        end else if (pop_s) begin
            r_valid_nxt_s   = 1'b0;
            r_last_nxt_s    = 1'b0;
        end else begin
            r_valid_nxt_s   = r_valid_r;
        end
    end

    // Sequencer state and registered R channel outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r     <= ST_IDLE;
            wait_r      <= '0;
            beat_r      <= '0;
            beat_addr_r <= '0;
            r_valid_r   <= 1'b0;
            r_id_r      <= '0;
            r_data_r    <= '0;
            r_resp_r    <= 2'b00;
            r_last_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            wait_r      <= wait_nxt_s;
            beat_r      <= beat_nxt_s;
            beat_addr_r <= beat_addr_nxt_s;
            r_valid_r   <= r_valid_nxt_s;
            r_id_r      <= r_id_nxt_s;
            r_data_r    <= r_data_nxt_s;
            r_resp_r    <= r_resp_nxt_s;
            r_last_r    <= r_last_nxt_s;
        end
    end

    // Request queue storage, pointers, occupancy and AR ready.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_addr_r[i] <= '0;
                q_len_r[i]  <= '0;
                q_id_r[i]   <= '0;
                q_err_r[i]  <= 1'b0;
            end
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            ar_ready_r <= 1'b0;
        end else begin
            if (ar_hs_s) begin
                q_addr_r[wr_ptr_r] <= s_ar_addr;
                q_len_r[wr_ptr_r]  <= s_ar_len;
                q_id_r[wr_ptr_r]   <= s_ar_id;
                q_err_r[wr_ptr_r]  <= ar_err_s;
                wr_ptr_r           <= wr_ptr_r + PTR_W'(1'b1);
            end else begin
                wr_ptr_r           <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r    <= count_nxt_s;
            ar_ready_r <= ar_ready_nxt_s;
        end
    end

endmodule

// File: tb/tb_axi_rd_subordinate.sv
// Directed plus randomized bench for axi_rd_subordinate. A queue-based model
// of accepted requests predicts every beat, its ID/resp/last, first-beat
// timing and queue occupancy; the DUT is sampled on the falling clock edge.
module tb_axi_rd_subordinate;

    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int LW  = 8;
    localparam int IW  = 8;
    localparam int LOGO = 2;
    localparam int LAT = 4;
    localparam int QDEPTH = 4;

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic [AW-1:0] bar = '0;
    logic [AW-1:0] limit = 64'hFFFF;
    logic          s_ar_valid = 1'b0;
    logic          s_ar_ready;
    logic [AW-1:0] s_ar_addr = '0;
    logic [LW-1:0] s_ar_len = '0;
    logic [IW-1:0] s_ar_id = '0;
    logic          s_r_valid;
    logic          s_r_ready = 1'b0;
    logic [IW-1:0] s_r_id;
    logic [DW-1:0] s_r_data;
    logic [1:0]    s_r_resp;
    logic          s_r_last;
    logic [LOGO:0] outstanding;

    always #5 clk = ~clk;

    axi_rd_subordinate #(
        .ADDR_BITS(AW), .DATA_WIDTH(DW), .BURST_LEN_WIDTH(LW), .TID_WIDTH(IW),
        .LOG_OUTSTANDING(LOGO), .READ_LATENCY(LAT)
    ) dut (
        .clk(clk), .resetN(resetN), .bar(bar), .limit(limit),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
        .s_ar_len(s_ar_len), .s_ar_id(s_ar_id),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id),
        .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last),
        .outstanding(outstanding)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [IW-1:0] id;
        logic          err;
        int            acc;
    } req_t;

    req_t          rq[$];
    logic [IW-1:0] done_ids[$];
    logic [1:0]    done_resp[$];
    int            vectors = 0;
    int            miscompares = 0;
    int            edge_n = 0;
    int            last_done = 0;
    int            beat_i = 0;
    int            hs_cnt = 0;
    int            rmode = 0;
    bit            mon_on = 1'b0;
    bit            in_burst = 1'b0;
    bit            stall_pend = 1'b0;
    bit            acc_seen = 1'b0;
    logic [DW-1:0] held_data;
    logic [IW-1:0] held_id;
    logic [1:0]    held_resp;
    logic          held_last;
    logic [DW-1:0] last_data = '0;
    logic [3:0]    pat = 4'b1001;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample and score at negedge, then advance past the rising edge.
    task automatic step();
        int            st;
        logic [DW-1:0] exp_data;
        @(negedge clk);
        acc_seen = s_ar_valid && s_ar_ready;
        if (mon_on) begin
            check("outstanding", 64'(outstanding), 64'(rq.size()));
            check("ar_ready", 64'(s_ar_ready), 64'(rq.size() < QDEPTH));
            if (stall_pend) begin
                check("stall_valid", 64'(s_r_valid), 64'd1);
                check("stall_data", s_r_data, held_data);
                check("stall_id", 64'(s_r_id), 64'(held_id));
                check("stall_resp", 64'(s_r_resp), 64'(held_resp));
                check("stall_last", 64'(s_r_last), 64'(held_last));
            end
            if (s_r_valid && rq.size() == 0) begin
                check("r_valid_without_request", 64'(s_r_valid), 64'd0);
            end else if (s_r_valid) begin
                if (!in_burst) begin
                    st = (rq[0].acc > last_done) ? rq[0].acc : last_done;
                    check("first_beat_edge", 64'(edge_n), 64'(st + LAT));
                    in_burst = 1'b1;
                    beat_i = 0;
                end
                if (s_r_ready) begin
                    exp_data = rq[0].err ? 64'd0 : rq[0].addr + 64'(beat_i) * 64'd8;
                    check("r_data", s_r_data, exp_data);
                    check("r_id", 64'(s_r_id), 64'(rq[0].id));
                    check("r_resp", 64'(s_r_resp), rq[0].err ? 64'd2 : 64'd0);
                    check("r_last", 64'(s_r_last), 64'(beat_i == int'(rq[0].len)));
                    hs_cnt++;
                    last_data = s_r_data;
                    if (beat_i == int'(rq[0].len)) begin
                        done_ids.push_back(s_r_id);
                        done_resp.push_back(s_r_resp);
                        void'(rq.pop_front());
                        last_done = edge_n + 1;
                        in_burst = 1'b0;
                    end else begin
                        beat_i++;
                    end
                end
            end
            stall_pend = s_r_valid && !s_r_ready;
            held_data = s_r_data;
            held_id   = s_r_id;
            held_resp = s_r_resp;
            held_last = s_r_last;
            if (acc_seen) begin
                rq.push_back('{addr: s_ar_addr, len: s_ar_len, id: s_ar_id,
                               err: (s_ar_addr < bar) || (s_ar_addr > limit), acc: edge_n + 1});
            end
        end
        @(posedge clk);
        edge_n++;
        #1;
        if (rmode == 1) s_r_ready = pat[edge_n % 4];
        else if (rmode == 2) s_r_ready = 1'($urandom_range(0, 1));
    endtask

    // Present a request and step until it is accepted; valid is left high.
    task automatic send(input logic [AW-1:0] a, input logic [LW-1:0] l,
                        input logic [IW-1:0] id, input int bound);
        s_ar_valid = 1'b1;
        s_ar_addr  = a;
        s_ar_len   = l;
        s_ar_id    = id;
        acc_seen   = 1'b0;
        for (int k = 0; k < bound && !acc_seen; k++) step();
        check("ar_accepted", 64'(acc_seen), 64'd1);
    endtask

    task automatic drain(input int bound);
        s_ar_valid = 1'b0;
        for (int k = 0; k < bound && rq.size() != 0; k++) step();
        check("drain_complete", 64'(rq.size()), 64'd0);
    endtask

    task automatic clear_stats();
        hs_cnt = 0;
        done_ids.delete();
        done_resp.delete();
    endtask

    initial begin
        int n5;
        int gap;
        logic [AW-1:0] ra;

        // Reset values
        #12;
        check("rst_ar_ready", 64'(s_ar_ready), 64'd0);
        check("rst_r_valid", 64'(s_r_valid), 64'd0);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_r_data", s_r_data, 64'd0);
        check("rst_r_last", 64'(s_r_last), 64'd0);
        check("rst_r_id", 64'(s_r_id), 64'd0);
        check("rst_r_resp", 64'(s_r_resp), 64'd0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        check("ar_ready_before_first_edge", 64'(s_ar_ready), 64'd0);
        step();
        edge_n = 0;
        last_done = 0;
        check("ar_ready_after_first_edge", 64'(s_ar_ready), 64'd1);
        mon_on = 1'b1;

        // Single request
        clear_stats();
        s_r_ready = 1'b1;
        send(64'h100, 8'd3, 8'd5, 10);
        drain(40);
        check("single_beats", 64'(hs_cnt), 64'd4);
        check("single_last_data", last_data, 64'h118);

        // Backpressure 1,0,0,1 pattern
        clear_stats();
        rmode = 1;
        send(64'h100, 8'd3, 8'd5, 10);
        drain(80);
        rmode = 0;
        check("bp_beats", 64'(hs_cnt), 64'd4);

        // Full queue
        clear_stats();
        s_r_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(64'h40 * i, 8'd0, 8'(i), 10);
        s_ar_addr = 64'h500;
        s_ar_len  = 8'd0;
        s_ar_id   = 8'd5;
        n5 = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (acc_seen) n5++;
        end
        check("full_fifth_held_off", 64'(n5), 64'd0);
        check("full_ar_ready", 64'(s_ar_ready), 64'd0);
        check("full_outstanding", 64'(outstanding), 64'd4);
        s_r_ready = 1'b1;
        send(64'h500, 8'd0, 8'd5, 20);
        drain(80);
        check("full_count", 64'(done_ids.size()), 64'd5);
        for (int i = 0; i < 5 && i < done_ids.size(); i++) check("full_id_order", 64'(done_ids[i]), 64'(i + 1));

        // Range error then in-range
        clear_stats();
        send(64'h20000, 8'd1, 8'd7, 10);
        send(64'h40, 8'd0, 8'd8, 10);
        drain(60);
        check("err_beats", 64'(hs_cnt), 64'd3);
        if (done_resp.size() == 2) begin
            check("err_resp", 64'(done_resp[0]), 64'd2);
            check("ok_resp_after_err", 64'(done_resp[1]), 64'd0);
        end else begin
            check("err_burst_count", 64'(done_resp.size()), 64'd2);
        end

        // Longest burst
        clear_stats();
        send(64'h1000, 8'd255, 8'd3, 10);
        drain(400);
        check("len255_beats", 64'(hs_cnt), 64'd256);
        check("len255_last_data", last_data, 64'h17F8);

        // Address wrap at the top of the space
        clear_stats();
        limit = '1;
        send(64'hFFFF_FFFF_FFFF_FFF8, 8'd1, 8'd4, 10);
        drain(40);
        check("wrap_beats", 64'(hs_cnt), 64'd2);
        check("wrap_second_data", last_data, 64'd0);
        limit = 64'hFFFF;

        // Reset during beat 2 of 4
        clear_stats();
        send(64'h300, 8'd3, 8'd9, 10);
        s_ar_valid = 1'b0;
        for (int k = 0; k < 40 && !(in_burst && beat_i == 1); k++) step();
        check("reset_reached_beat2", 64'(beat_i), 64'd1);
        resetN = 1'b0;
        #1;
        check("midrst_r_valid", 64'(s_r_valid), 64'd0);
        check("midrst_outstanding", 64'(outstanding), 64'd0);
        check("midrst_ar_ready", 64'(s_ar_ready), 64'd0);
        mon_on = 1'b0;
        rq.delete();
        in_burst = 1'b0;
        stall_pend = 1'b0;
        step();
        step();
        resetN = 1'b1;
        step();
        last_done = edge_n;
        mon_on = 1'b1;
        clear_stats();
        send(64'h800, 8'd2, 8'd11, 10);
        drain(40);
        check("post_reset_beats", 64'(hs_cnt), 64'd3);
        check("post_reset_last_data", last_data, 64'h810);

        // Randomized traffic
        rmode = 2;
        for (int n = 0; n < 150; n++) begin
            if (rq.size() == 0 && $urandom_range(0, 3) == 0) begin
                bar   = 64'($urandom_range(0, 32'h1FFFF));
                limit = bar + 64'($urandom_range(0, 32'h1FFFF));
            end
            if ($urandom_range(0, 7) == 0) ra = {32'hFFFF_FFFF, 32'($urandom())};
            else ra = 64'($urandom_range(0, 32'h3FFFF));
            send(ra, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1000);
            s_ar_valid = 1'b0;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) step();
        end
        drain(2000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
